// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Status delivered alongside each received word.
    typedef struct packed {
        logic frame_err;
        logic parity_err;
        logic break_det;
    } rx_flags_t;

    // 2-of-3 majority vote used for noise-tolerant bit sampling.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Free-running oversample tick: one-clk pulse every CLK_DIV clocks.
module uart_rx_tick_gen #(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic clk,
    input  logic reset,
    output logic os_tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wrap the divider at CLK_DIV-1.
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end

    // Divider register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign os_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, majority sampling, false-start
// rejection, error flags and a valid/ready output handshake.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 5,
    parameter int unsigned OVERSAMPLE  = 8,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 2,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = 4;
    localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_MID_M1 = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID_M2 = SW'(OVERSAMPLE / 2 - 2);
    localparam logic [BW-1:0] D_LAST   = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STP_LAST = BW'(STOP_BITS - 1);

    logic                 os_tick;
    logic                 sync1_q;
    logic                 rx_s_q;

    rx_state_e            state_q, state_d;
    logic [SW-1:0]        s_cnt_q, s_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           samp_q, samp_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 pbit_q, pbit_d;

    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    rx_flags_t            flags_q, flags_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;

    logic [SW-1:0]        s_idx_c;
    logic                 dec_c;
    logic                 exp_par_c;
    logic                 done_c;
    rx_flags_t            done_flags_c;

    uart_rx_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .os_tick (os_tick)
    );

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
        end
    end

    // Frame FSM: s_cnt holds the index of the current tick within the bit,
    // with the start-detect tick as index 0.
    always_comb begin
        state_d      = state_q;
        s_cnt_d      = s_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        samp_d       = samp_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        pbit_d       = pbit_q;
        done_c       = 1'b0;
        s_idx_c      = (s_cnt_q == S_LAST) ? '0 : s_cnt_q + SW'(1);
        dec_c        = maj3(samp_q[0], samp_q[1], rx_s_q);
        exp_par_c    = (PARITY_MODE == PAR_EVEN) ? ^shift_q : ~^shift_q;
        done_flags_c = '{frame_err:  ferr_q | ~dec_c,
                         parity_err: perr_q,
                         break_det:  (shift_q == '0) & ~pbit_q & (ferr_q | ~dec_c)};

        if (os_tick) begin
            if (state_q != IDLE) begin
                s_cnt_d = s_idx_c;
                if (s_idx_c == S_MID_M2) samp_d[0] = rx_s_q;
                if (s_idx_c == S_MID_M1) samp_d[1] = rx_s_q;
            end
            unique case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d   = START;
                        s_cnt_d   = '0;
                        bit_cnt_d = '0;
                        perr_d    = 1'b0;
                        ferr_d    = 1'b0;
                        pbit_d    = 1'b0;
                    end
                end
                START: begin
                    if (s_idx_c == S_MID && dec_c) begin
                        state_d = IDLE;
                    end else if (s_idx_c == S_LAST) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    if (s_idx_c == S_MID) begin
                        shift_d = {dec_c, shift_q[DATA_BITS-1:1]};
                    end
                    if (s_idx_c == S_LAST) begin
                        if (bit_cnt_q == D_LAST) begin
                            state_d   = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (s_idx_c == S_MID) begin
                        pbit_d = dec_c;
                        perr_d = (dec_c != exp_par_c);
                    end
                    if (s_idx_c == S_LAST) begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                    end
                end
                STOP: begin
                    if (s_idx_c == S_MID) begin
                        if (!dec_c) ferr_d = 1'b1;
                        if (bit_cnt_q == STP_LAST) begin
                            done_c  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    if (s_idx_c == S_LAST) begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output handshake: load on completion unless a held word is unconsumed.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        flags_d    = flags_q;
        overrun_d  = 1'b0;
        busy_d     = (state_d != IDLE);
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (done_c) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                flags_d    = done_flags_c;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            s_cnt_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            samp_q     <= '1;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            pbit_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            flags_q    <= '0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_cnt_q    <= s_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            samp_q     <= samp_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            pbit_q     <= pbit_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            flags_q    <= flags_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = flags_q.frame_err;
    assign parity_err  = flags_q.parity_err;
    assign break_det   = flags_q.break_det;
    assign overrun_err = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench: default receiver (8 data, odd parity, 1 stop) and a
// 7-bit, no-parity, 2-stop receiver sharing clock and reset.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int BIT_CLK = 40;

    typedef struct packed {
        logic [8:0] d;
        logic       fe;
        logic       pe;
        logic       bk;
        int         cyc;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_a, rx_b, rdy_a, rdy_b;
    logic [7:0] a_data;
    logic [6:0] b_data;
    logic       a_valid, a_fe, a_pe, a_bk, a_ovr, a_busy;
    logic       b_valid, b_fe, b_pe, b_bk, b_ovr, b_busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   vcnt_a = 0;
    int   ovr_cnt_a = 0;
    int   rd_a = 0;
    int   rd_b = 0;
    obs_t got_a[$];
    obs_t got_b[$];
    obs_t exp_a[$];
    obs_t exp_b[$];

    always #5 clk = ~clk;

    uart_rx_param dut_a (
        .clk (clk), .reset (reset), .rx (rx_a), .rx_data (a_data),
        .rx_valid (a_valid), .rx_ready (rdy_a), .frame_err (a_fe),
        .parity_err (a_pe), .break_det (a_bk), .overrun_err (a_ovr), .busy (a_busy)
    );

    uart_rx_param #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) dut_b (
        .clk (clk), .reset (reset), .rx (rx_b), .rx_data (b_data),
        .rx_valid (b_valid), .rx_ready (rdy_b), .frame_err (b_fe),
        .parity_err (b_pe), .break_det (b_bk), .overrun_err (b_ovr), .busy (b_busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every accepted word and count valid/overrun cycles.
    always @(negedge clk) begin
        obs_t o;
        if (a_valid) vcnt_a = vcnt_a + 1;
        if (a_ovr) ovr_cnt_a = ovr_cnt_a + 1;
        if (a_valid && rdy_a) begin
            o = '{d: {1'b0, a_data}, fe: a_fe, pe: a_pe, bk: a_bk, cyc: cyc};
            got_a.push_back(o);
        end
        if (b_valid && rdy_b) begin
            o = '{d: {2'b00, b_data}, fe: b_fe, pe: b_pe, bk: b_bk, cyc: cyc};
            got_b.push_back(o);
        end
    end

    // Reference for the odd-parity receiver: total ones including parity must be odd.
    function automatic obs_t model_a(input logic [7:0] d, input logic par, input logic stop);
        obs_t e;
        e.d   = {1'b0, d};
        e.fe  = ~stop;
        e.pe  = ((($countones(d) + int'(par)) % 2) == 0);
        e.bk  = (d == 8'h00) && !par && !stop;
        e.cyc = 0;
        return e;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    // Serialise one frame LSB first; par < 0 means no parity bit.
    task automatic send(input bit sel, input logic [8:0] d, input int nd, input int par,
                        input int nstop, input logic stop_v, input int gbit, output int t0);
        logic [15:0] fr;
        logic [3:0]  n;
        fr = '1;
        n  = 4'd0;
        fr[n] = 1'b0;
        n = n + 4'd1;
        for (int i = 0; i < nd; i++) begin
            fr[n] = d[4'(i)];
            n = n + 4'd1;
        end
        if (par >= 0) begin
            fr[n] = par[0];
            n = n + 4'd1;
        end
        for (int i = 0; i < nstop; i++) begin
            fr[n] = stop_v;
            n = n + 4'd1;
        end
        t0 = cyc;
        for (int i = 0; i < int'(n); i++) begin
            drive(sel, fr[4'(i)]);
            if (i == gbit) begin
                wait_clk(20);
                drive(sel, 1'b0);
                wait_clk(1);
                drive(sel, fr[4'(i)]);
                wait_clk(BIT_CLK - 21);
            end else begin
                wait_clk(BIT_CLK);
            end
        end
        drive(sel, 1'b1);
        wait_clk(60);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_clk(3);
        checks++;
        if ({a_data, a_valid, a_fe, a_pe, a_bk, a_ovr, a_busy} !== 14'h0) begin
            errors++;
            $display("FAIL reset_a_in got %h required 0", {a_data, a_valid, a_fe, a_pe, a_bk, a_ovr, a_busy});
        end
        checks++;
        if ({b_data, b_valid, b_fe, b_pe, b_bk, b_ovr, b_busy} !== 13'h0) begin
            errors++;
            $display("FAIL reset_b_in got %h required 0", {b_data, b_valid, b_fe, b_pe, b_bk, b_ovr, b_busy});
        end
        reset = 1'b0;
        wait_clk(5);
        checks++;
        if ({a_data, a_valid, a_fe, a_pe, a_bk, a_ovr, a_busy} !== 14'h0) begin
            errors++;
            $display("FAIL reset_a_after got %h required 0", {a_data, a_valid, a_fe, a_pe, a_bk, a_ovr, a_busy});
        end
        checks++;
        if ({b_data, b_valid, b_fe, b_pe, b_bk, b_ovr, b_busy} !== 13'h0) begin
            errors++;
            $display("FAIL reset_b_after got %h required 0", {b_data, b_valid, b_fe, b_pe, b_bk, b_ovr, b_busy});
        end
    endtask

    task automatic test_parity();
        logic [7:0] dv [3] = '{8'hA5, 8'hA5, 8'h5A};
        logic       pv [3] = '{1'b1, 1'b0, 1'b1};
        obs_t o, e;
        int   t0, vc0;
        for (int i = 0; i < 3; i++) begin
            vc0 = vcnt_a;
            exp_a.push_back(model_a(dv[i], pv[i], 1'b1));
            send(1'b0, {1'b0, dv[i]}, 8, int'(pv[i]), 1, 1'b1, -1, t0);
            e = exp_a.pop_front();
            checks++;
            if (got_a.size() <= rd_a) begin
                errors++;
                $display("FAIL parity_frame%0d got %0d words required %0d", i, got_a.size(), rd_a + 1);
            end else begin
                o = got_a[rd_a];
                rd_a++;
                if ({o.d, o.fe, o.pe, o.bk} !== {e.d, e.fe, e.pe, e.bk}) begin
                    errors++;
                    $display("FAIL parity_frame%0d got d=%h fe=%b pe=%b bk=%b required d=%h fe=%b pe=%b bk=%b",
                             i, o.d, o.fe, o.pe, o.bk, e.d, e.fe, e.pe, e.bk);
                end
            end
            checks++;
            if (vcnt_a - vc0 != 1) begin
                errors++;
                $display("FAIL valid_width%0d got %0d clk required 1", i, vcnt_a - vc0);
            end
        end
    endtask

    task automatic test_false_start();
        obs_t o, e;
        int   t0, vc0, n0;
        bit   seen, idle;
        vc0 = vcnt_a;
        n0  = got_a.size();
        rx_a = 1'b0;
        wait_clk(8);
        rx_a = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (a_busy) seen = 1'b1;
            wait_clk(1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL false_start_busy got 0 required 1");
        end
        idle = 1'b0;
        for (int k = 0; k < 100 && !idle; k++) begin
            if (!a_busy) idle = 1'b1;
            else wait_clk(1);
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL false_start_idle got busy=1 required 0");
        end
        wait_clk(60);
        checks++;
        if (vcnt_a != vc0 || got_a.size() != n0) begin
            errors++;
            $display("FAIL false_start_out got %0d valid clk required 0", vcnt_a - vc0);
        end
        exp_a.push_back(model_a(8'hFF, 1'b1, 1'b1));
        send(1'b0, 9'h0FF, 8, 1, 1, 1'b1, 4, t0);
        e = exp_a.pop_front();
        checks++;
        if (got_a.size() <= rd_a) begin
            errors++;
            $display("FAIL glitch_frame got %0d words required %0d", got_a.size(), rd_a + 1);
        end else begin
            o = got_a[rd_a];
            rd_a++;
            if ({o.d, o.fe, o.pe, o.bk} !== {e.d, e.fe, e.pe, e.bk}) begin
                errors++;
                $display("FAIL glitch_frame got d=%h fe=%b pe=%b bk=%b required d=%h fe=%b pe=%b bk=%b",
                         o.d, o.fe, o.pe, o.bk, e.d, e.fe, e.pe, e.bk);
            end
        end
    endtask

    task automatic test_break_frame();
        logic [7:0] dv [2] = '{8'h00, 8'h3C};
        logic       pv [2] = '{1'b0, 1'b1};
        obs_t o, e;
        int   t0;
        for (int i = 0; i < 2; i++) begin
            exp_a.push_back(model_a(dv[i], pv[i], 1'b0));
            send(1'b0, {1'b0, dv[i]}, 8, int'(pv[i]), 1, 1'b0, -1, t0);
            e = exp_a.pop_front();
            checks++;
            if (got_a.size() <= rd_a) begin
                errors++;
                $display("FAIL stop_err%0d got %0d words required %0d", i, got_a.size(), rd_a + 1);
            end else begin
                o = got_a[rd_a];
                rd_a++;
                if ({o.d, o.fe, o.pe, o.bk} !== {e.d, e.fe, e.pe, e.bk}) begin
                    errors++;
                    $display("FAIL stop_err%0d got d=%h fe=%b pe=%b bk=%b required d=%h fe=%b pe=%b bk=%b",
                             i, o.d, o.fe, o.pe, o.bk, e.d, e.fe, e.pe, e.bk);
                end
            end
        end
    endtask

    task automatic test_overrun();
        obs_t o, e;
        int   t0, ov0;
        rdy_a = 1'b0;
        ov0 = ovr_cnt_a;
        exp_a.push_back(model_a(8'h11, 1'b1, 1'b1));
        send(1'b0, 9'h011, 8, 1, 1, 1'b1, -1, t0);
        send(1'b0, 9'h022, 8, 1, 1, 1'b1, -1, t0);
        checks++;
        if (ovr_cnt_a - ov0 != 1) begin
            errors++;
            $display("FAIL overrun_pulses got %0d required 1", ovr_cnt_a - ov0);
        end
        checks++;
        if (a_valid !== 1'b1 || a_data !== 8'h11) begin
            errors++;
            $display("FAIL overrun_hold got valid=%b data=%h required valid=1 data=11", a_valid, a_data);
        end
        rdy_a = 1'b1;
        wait_clk(2);
        e = exp_a.pop_front();
        checks++;
        if (got_a.size() <= rd_a) begin
            errors++;
            $display("FAIL overrun_accept got %0d words required %0d", got_a.size(), rd_a + 1);
        end else begin
            o = got_a[rd_a];
            rd_a++;
            if ({o.d, o.fe, o.pe, o.bk} !== {e.d, e.fe, e.pe, e.bk}) begin
                errors++;
                $display("FAIL overrun_accept got d=%h fe=%b pe=%b bk=%b required d=%h fe=%b pe=%b bk=%b",
                         o.d, o.fe, o.pe, o.bk, e.d, e.fe, e.pe, e.bk);
            end
        end
        checks++;
        if (a_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_drop got valid=%b required 0", a_valid);
        end
        exp_a.push_back(model_a(8'h33, 1'b1, 1'b1));
        send(1'b0, 9'h033, 8, 1, 1, 1'b1, -1, t0);
        e = exp_a.pop_front();
        checks++;
        if (got_a.size() <= rd_a) begin
            errors++;
            $display("FAIL after_overrun got %0d words required %0d", got_a.size(), rd_a + 1);
        end else begin
            o = got_a[rd_a];
            rd_a++;
            if ({o.d, o.fe, o.pe, o.bk} !== {e.d, e.fe, e.pe, e.bk}) begin
                errors++;
                $display("FAIL after_overrun got d=%h fe=%b pe=%b bk=%b required d=%h fe=%b pe=%b bk=%b",
                         o.d, o.fe, o.pe, o.bk, e.d, e.fe, e.pe, e.bk);
            end
        end
    endtask

    task automatic test_alt_config();
        obs_t o, e;
        int   t0;
        rx_b = 1'b0;
        wait_clk(3 * BIT_CLK);
        checks++;
        if (b_busy !== 1'b1) begin
            errors++;
            $display("FAIL alt_mid_frame_busy got %b required 1", b_busy);
        end
        reset = 1'b1;
        rx_b  = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        wait_clk(2);
        checks++;
        if ({b_data, b_valid, b_fe, b_pe, b_bk, b_ovr, b_busy} !== 13'h0) begin
            errors++;
            $display("FAIL alt_reset got %h required 0", {b_data, b_valid, b_fe, b_pe, b_bk, b_ovr, b_busy});
        end
        wait_clk(100);
        checks++;
        if (got_b.size() != rd_b || b_valid !== 1'b0) begin
            errors++;
            $display("FAIL alt_abort got %0d words required 0", got_b.size() - rd_b);
        end
        exp_b.push_back('{d: 9'h03C, fe: 1'b0, pe: 1'b0, bk: 1'b0, cyc: 0});
        send(1'b1, 9'h03C, 7, -1, 2, 1'b1, -1, t0);
        e = exp_b.pop_front();
        checks++;
        if (got_b.size() <= rd_b) begin
            errors++;
            $display("FAIL alt_frame got %0d words required %0d", got_b.size(), rd_b + 1);
        end else begin
            o = got_b[rd_b];
            rd_b++;
            if ({o.d, o.fe, o.pe, o.bk} !== {e.d, e.fe, e.pe, e.bk}) begin
                errors++;
                $display("FAIL alt_frame got d=%h fe=%b pe=%b bk=%b required d=%h fe=%b pe=%b bk=%b",
                         o.d, o.fe, o.pe, o.bk, e.d, e.fe, e.pe, e.bk);
            end
            // Stop bit 2 spans clk 360..400 of the frame; its centre is 380.
            checks++;
            if (o.cyc - t0 < 375 || o.cyc - t0 > 395) begin
                errors++;
                $display("FAIL alt_timing got %0d clk required 375..395", o.cyc - t0);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        test_reset();
        test_parity();
        test_false_start();
        test_break_frame();
        test_overrun();
        test_alt_config();
        wait_clk(10);
        checks++;
        if (exp_a.size() != 0 || got_a.size() != rd_a || got_b.size() != rd_b) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d/%0d/%0d leftovers required 0/0/0",
                     exp_a.size(), got_a.size() - rd_a, got_b.size() - rd_b);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
